// File: rtl/status_pkg.sv
// -----------------------------------------------------------------------------
// status_pkg
// Shared types and constants for the status display scan controller.
//   scan_state_e : scan FSM states (IDLE, CLEAR, SHOW)
//   temp_t       : signed 8-bit temperature sample
//   HOT_LIMIT_C  : default upper alarm limit (sample > limit is an alarm)
//   COLD_LIMIT_C : default lower alarm limit (sample < limit is an alarm)
//   is_alarm()   : signed range check of one sample against both limits
// -----------------------------------------------------------------------------
package status_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    typedef logic signed [7:0] temp_t;

    localparam int HOT_LIMIT_C  = 60;
    localparam int COLD_LIMIT_C = -50;

    // Sign-extend the sample to int so the compare is signed regardless of
    // how the limits were declared.
    function automatic logic is_alarm(input temp_t s, input int hot, input int cold);
        return (int'(s) > hot) || (int'(s) < cold);
    endfunction

endpackage

// File: rtl/status_scan_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin next-set-bit finder.
// Searches req_i starting at start_i+1, wrapping around, and tests start_i
// itself last. Passing start_i = NUM_CH-1 therefore yields the lowest set bit.
// Ports:
//   req_i   in  NUM_CH          request mask
//   start_i in  $clog2(NUM_CH)  index the search starts after
//   found_o out 1               at least one request bit is set
//   idx_o   out $clog2(NUM_CH)  first set index in search order (0 if none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] start_i,
    output logic                      found_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o
);

    localparam int IW = $clog2(NUM_CH);

    logic [IW-1:0] cand;

    // Walk from the farthest offset back to the nearest one so that the
    // nearest hit after start_i overwrites any farther hit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = IW'((int'(start_i) + off) % NUM_CH);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/status_scan_ctrl.sv
// -----------------------------------------------------------------------------
// status_scan_ctrl
// Shares one 14-segment status display between NUM_CH temperature channels.
// Captures each channel's latest signed sample, scans channels round-robin
// with a fixed dwell, lets alarmed channels preempt the normal scan, and
// pulses a one-cycle display clear before every channel switch.
// Ports:
//   clk_i          in  1              system clock
//   rst_ni         in  1              asynchronous active-low reset
//   enable_i       in  1              scan enable (low forces IDLE)
//   sample_i       in  NUM_CH*8       signed samples, channel k at [8k +: 8]
//   sample_valid_i in  NUM_CH         per-channel capture strobe
//   data_o         out 8              signed sample for the display
//   chan_o         out $clog2(NUM_CH) channel currently shown
//   disp_clear_o   out 1              one-cycle display clear
//   alarm_o        out 1              shown channel is in alarm
// -----------------------------------------------------------------------------
module status_scan_ctrl
    import status_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DWELL_CYCLES = 4,
    parameter int HOT_LIMIT    = HOT_LIMIT_C,
    parameter int COLD_LIMIT   = COLD_LIMIT_C
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [NUM_CH*8-1:0]       sample_i,
    input  logic [NUM_CH-1:0]         sample_valid_i,
    output logic signed [7:0]         data_o,
    output logic [$clog2(NUM_CH)-1:0] chan_o,
    output logic                      disp_clear_o,
    output logic                      alarm_o
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] LAST_CH    = IW'(NUM_CH - 1);

    // -------------------------------------------------------------------------
    // Sample capture
    // -------------------------------------------------------------------------
    temp_t             samples_q [NUM_CH];
    logic [NUM_CH-1:0] has_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                samples_q[k] <= '0;
            end
            has_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sample_valid_i[k]) begin
                    samples_q[k]  <= sample_i[k*8 +: 8];
                    has_data_q[k] <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Alarm vector, evaluated combinationally from the stored samples so that
    // a capture at one edge can already steer the FSM at the next edge.
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] alarm;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_alarm
        assign alarm[gi] = has_data_q[gi] & is_alarm(samples_q[gi], HOT_LIMIT, COLD_LIMIT);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] chan_q, chan_d;
    temp_t         data_q, data_d;
    logic          clear_q, clear_d;
    logic          alarm_q, alarm_d;

    // -------------------------------------------------------------------------
    // Channel pickers
    // -------------------------------------------------------------------------
    logic          preempt;
    logic [IW-1:0] pick_start;
    logic          alarm_found, data_found;
    logic [IW-1:0] alarm_idx, data_idx;
    logic [IW-1:0] next_chan;

    // A non-alarmed channel in SHOW gives way as soon as any alarm exists.
    assign preempt = (state_q == SHOW) && !alarm[chan_q] && (|alarm);

    // Dwell expiry searches after the current channel; the first pick out of
    // IDLE and a preemption both want the lowest index, which is what a
    // search starting after the last channel produces.
    assign pick_start = ((state_q == SHOW) && !preempt) ? chan_q : LAST_CH;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick_alarm (
        .req_i   (alarm),
        .start_i (pick_start),
        .found_o (alarm_found),
        .idx_o   (alarm_idx)
    );

    rr_pick #(.NUM_CH(NUM_CH)) u_pick_data (
        .req_i   (has_data_q),
        .start_i (pick_start),
        .found_o (data_found),
        .idx_o   (data_idx)
    );

    // Alarmed channels take precedence over ordinary ones in every pick.
    assign next_chan = alarm_found ? alarm_idx : data_idx;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;

        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_found) begin
                        state_d = CLEAR;
                        chan_d  = next_chan;
                    end
                end
                CLEAR: begin
                    state_d = SHOW;
                    cnt_d   = DWELL_LOAD;
                end
                SHOW: begin
                    if (preempt) begin
                        state_d = CLEAR;
                        chan_d  = next_chan;
                    end else if (cnt_q == '0) begin
                        // Same channel picked again: keep showing it without
                        // restarting the display history.
                        if (next_chan != chan_q) begin
                            state_d = CLEAR;
                            chan_d  = next_chan;
                        end else begin
                            cnt_d = DWELL_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are registered, so they are derived from the next state and
        // next channel; a sample update reaches data_o one cycle after capture.
        clear_d = (state_d == CLEAR);
        data_d  = (state_d == SHOW) ? samples_q[chan_d] : '0;
        alarm_d = (state_d == SHOW) ? alarm[chan_d] : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            clear_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            clear_q <= clear_d;
            alarm_q <= alarm_d;
        end
    end

    assign data_o       = data_q;
    assign chan_o       = chan_q;
    assign disp_clear_o = clear_q;
    assign alarm_o      = alarm_q;

endmodule
